// File: rtl/dmem_unit_if.sv
// rtl/dmem_unit_if.sv - request/done bus between the M-stage control and dmem_unit
interface dmem_unit_if;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [3:0]  stat_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] rdata_o;
    logic [3:0]  stat_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, stat_i,
        input  busy_o, done_o, rdata_o, stat_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, stat_i,
        output busy_o, done_o, rdata_o, stat_o
    );
endinterface

// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - Y86-64 M-stage data memory with wait states, range check and registered result
module dmem_unit #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    dmem_unit_if.slave  bus
);
    localparam logic [3:0]  SAOK      = 4'h1;
    localparam logic [3:0]  SADR      = 4'h3;
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [63:0] LAST_ADDR = 64'(DEPTH - 8);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [3:0]      stat_q, stat_d;

    logic            accept, in_range, acc_valid;
    logic            exec_now, exec_wait, exec, exec_we;
    logic [AW-1:0]   exec_idx;
    logic [63:0]     exec_wdata, mem_word;

    logic [7:0]      mem [0:DEPTH-1];

    assign accept    = bus.req_i && (state_q != S_WAIT);
    assign in_range  = bus.addr_i <= LAST_ADDR;
    assign acc_valid = accept && (bus.stat_i == SAOK) && in_range;

    // With no wait states the access happens on the accepting edge, using the live inputs.
    assign exec_now  = acc_valid && (WAIT_CYCLES == 0);
    assign exec_wait = (state_q == S_WAIT) && (cnt_q == 4'd1);
    assign exec      = rstn_i && (exec_now || exec_wait);

    assign exec_we    = exec_now ? bus.we_i             : we_q;
    assign exec_idx   = exec_now ? bus.addr_i[AW-1:0]   : idx_q;
    assign exec_wdata = exec_now ? bus.wdata_i          : wdata_q;

    always_comb begin
        mem_word = '0;
        for (int k = 0; k < 8; k++) begin
            mem_word[8*k +: 8] = mem[exec_idx + AW'(k)];
        end
    end

    always_ff @(posedge clk_i) begin
        if (exec && exec_we) begin
            for (int k = 0; k < 8; k++) begin
                mem[exec_idx + AW'(k)] <= exec_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            stat_q  <= SAOK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            stat_q  <= stat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        stat_d  = stat_q;

        if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (exec_wait) begin
            state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end

        // A DONE cycle can accept the next request directly.
        if (accept) begin
            we_d    = bus.we_i;
            idx_d   = bus.addr_i[AW-1:0];
            wdata_d = bus.wdata_i;
            if (bus.stat_i != SAOK) begin
                stat_d  = bus.stat_i;
                rdata_d = '0;
                state_d = S_DONE;
            end else if (!in_range) begin
                stat_d  = SADR;
                rdata_d = '0;
                state_d = S_DONE;
            end else if (WAIT_CYCLES == 0) begin
                state_d = S_DONE;
            end else begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end
        end

        if (exec) begin
            stat_d  = SAOK;
            rdata_d = exec_we ? 64'd0 : mem_word;
        end
    end

    assign bus.busy_o  = (state_q == S_WAIT);
    assign bus.done_o  = (state_q == S_DONE);
    assign bus.rdata_o = rdata_q;
    assign bus.stat_o  = stat_q;
endmodule

// File: tb/tb_dmem_unit.sv
// tb/tb_dmem_unit.sv - scoreboard bench for dmem_unit with two wait-state configurations
module tb_dmem_unit;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] LAST  = 64'(DEPTH - 8);
    localparam logic [3:0]  SAOK  = 4'h1;
    localparam logic [3:0]  SHLT  = 4'h2;
    localparam logic [3:0]  SADR  = 4'h3;
    localparam logic [3:0]  SINS  = 4'h4;

    typedef struct {
        logic [63:0] rdata;
        logic [3:0]  stat;
        int          issue;
        int          lat;
        int          busy;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_a = 0;
    int   busy_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] mref [2][DEPTH];

    dmem_unit_if a_if();
    dmem_unit_if b_if();

    dmem_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (.clk_i(clk), .rstn_i(rstn), .bus(a_if.slave));
    dmem_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (.clk_i(clk), .rstn_i(rstn), .bus(b_if.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Reference: little-endian byte array, error classes take one cycle, valid accesses W+1.
    function automatic exp_t model(input int sel, input logic we, input logic [63:0] addr,
                                   input logic [63:0] wd, input logic [3:0] st);
        exp_t e;
        int   w;
        w       = (sel == 0) ? 2 : 0;
        e.rdata = 64'd0;
        e.lat   = 1;
        e.busy  = 0;
        e.issue = 0;
        if (st != SAOK) begin
            e.stat = st;
        end else if (addr > LAST) begin
            e.stat = SADR;
        end else begin
            e.stat = SAOK;
            e.lat  = w + 1;
            e.busy = w;
            for (int k = 0; k < 8; k++) begin
                if (we) mref[sel][int'(addr) + k] = wd[8*k +: 8];
                else    e.rdata[8*k +: 8] = mref[sel][int'(addr) + k];
            end
        end
        return e;
    endfunction

    task automatic idle(input int n);
        a_if.req_i = 1'b0;
        b_if.req_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input int sel, input logic we, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [3:0] st, input bit toggle);
        exp_t e;
        bit   seen;
        int   n;
        e       = model(sel, we, addr, wd, st);
        e.issue = cyc;
        if (sel == 0) begin
            b_if.req_i = 1'b0;
            a_if.req_i = 1'b1; a_if.we_i = we; a_if.addr_i = addr; a_if.wdata_i = wd; a_if.stat_i = st;
            qa.push_back(e);
        end else begin
            a_if.req_i = 1'b0;
            b_if.req_i = 1'b1; b_if.we_i = we; b_if.addr_i = addr; b_if.wdata_i = wd; b_if.stat_i = st;
            qb.push_back(e);
        end
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (sel == 0) begin
                if (a_if.done_o) begin
                    seen = 1'b1;
                end else if (toggle && a_if.busy_o) begin
                    a_if.req_i   = ~a_if.req_i;
                    a_if.we_i    = ~we;
                    a_if.addr_i  = 64'($urandom_range(0, DEPTH / 8 - 1)) * 64'd8;
                    a_if.wdata_i = {$urandom, $urandom};
                end
            end else begin
                seen = b_if.done_o;
            end
        end
        if (!seen) fail((sel == 0) ? "a.timeout" : "b.timeout");
    endtask

    task automatic compare_entry(input string tag, input exp_t e, input logic [63:0] rd,
                                 input logic [3:0] st, input int busy);
        chk({tag, ".rdata"}, rd, e.rdata);
        chk({tag, ".stat"}, 64'(st), 64'(e.stat));
        chk({tag, ".latency"}, 64'(cyc - e.issue), 64'(e.lat));
        chk({tag, ".busy_cycles"}, 64'(busy), 64'(e.busy));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            busy_a = 0;
            busy_b = 0;
        end else begin
            if (a_if.busy_o) busy_a++;
            if (a_if.done_o) begin
                if (qa.size() == 0) fail("a.spurious_done");
                else begin
                    e = qa.pop_front();
                    compare_entry("a", e, a_if.rdata_o, a_if.stat_o, busy_a);
                end
                busy_a = 0;
            end
            if (b_if.busy_o) busy_b++;
            if (b_if.done_o) begin
                if (qb.size() == 0) fail("b.spurious_done");
                else begin
                    e = qb.pop_front();
                    compare_entry("b", e, b_if.rdata_o, b_if.stat_o, busy_b);
                end
                busy_b = 0;
            end
        end
    end

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return 64'($urandom_range(0, DEPTH - 8));
        else if (r == 7) return LAST + 64'($urandom_range(0, 8)) - 64'd1;
        else if (r == 8) return {$urandom, $urandom} | 64'h1000;
        else             return 64'hFFFF_FFFF_FFFF_FFF8;
    endfunction

    function automatic logic [3:0] rand_stat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 6)      return SAOK;
        else if (r == 7) return SHLT;
        else if (r == 8) return SINS;
        else             return SADR;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_if.req_i = 1'b0; a_if.we_i = 1'b0; a_if.addr_i = '0; a_if.wdata_i = '0; a_if.stat_i = SAOK;
        b_if.req_i = 1'b0; b_if.we_i = 1'b0; b_if.addr_i = '0; b_if.wdata_i = '0; b_if.stat_i = SAOK;
        #1 rstn = 1'b0;
        #2;
        chk("reset.a.busy", 64'(a_if.busy_o), 64'd0);
        chk("reset.a.done", 64'(a_if.done_o), 64'd0);
        chk("reset.a.rdata", a_if.rdata_o, 64'd0);
        chk("reset.a.stat", 64'(a_if.stat_o), 64'(SAOK));
        chk("reset.b.busy", 64'(b_if.busy_o), 64'd0);
        chk("reset.b.done", 64'(b_if.done_o), 64'd0);
        chk("reset.b.rdata", b_if.rdata_o, 64'd0);
        chk("reset.b.stat", 64'(b_if.stat_o), 64'(SAOK));
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < DEPTH / 8; i++) issue(0, 1'b1, 64'(i * 8), {$urandom, $urandom}, SAOK, 1'b0);
        for (int i = 0; i < DEPTH / 8; i++) issue(1, 1'b1, 64'(i * 8), {$urandom, $urandom}, SAOK, 1'b0);
        idle(2);

        issue(0, 1'b1, 64'h10, 64'h1122334455667788, SAOK, 1'b0);
        idle(1);
        issue(0, 1'b0, 64'h10, 64'd0, SAOK, 1'b0);
        issue(0, 1'b0, 64'h11, 64'd0, SAOK, 1'b0);
        issue(0, 1'b1, 64'd1016, {$urandom, $urandom}, SAOK, 1'b0);
        issue(0, 1'b1, 64'd1017, {$urandom, $urandom}, SAOK, 1'b0);
        issue(0, 1'b0, 64'd1016, 64'd0, SAOK, 1'b0);
        issue(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, SAOK, 1'b0);
        issue(0, 1'b1, 64'h20, {$urandom, $urandom}, SHLT, 1'b0);
        issue(0, 1'b0, 64'h20, 64'd0, SAOK, 1'b0);
        issue(0, 1'b1, 64'h30, {$urandom, $urandom}, SAOK, 1'b1);
        issue(0, 1'b0, 64'h30, 64'd0, SAOK, 1'b0);
        idle(1);

        // Abort a write to 0x40 mid-wait; the result registers hold nonzero read data beforehand.
        issue(0, 1'b0, 64'h10, 64'd0, SAOK, 1'b0);
        b_if.req_i = 1'b0;
        a_if.req_i = 1'b1; a_if.we_i = 1'b1; a_if.addr_i = 64'h40;
        a_if.wdata_i = 64'hDEAD_BEEF_CAFE_F00D; a_if.stat_i = SAOK;
        @(negedge clk);
        chk("abort.busy_before", 64'(a_if.busy_o), 64'd1);
        #2 rstn = 1'b0;
        #1;
        chk("abort.busy", 64'(a_if.busy_o), 64'd0);
        chk("abort.done", 64'(a_if.done_o), 64'd0);
        chk("abort.rdata", a_if.rdata_o, 64'd0);
        chk("abort.stat", 64'(a_if.stat_o), 64'(SAOK));
        a_if.req_i = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 64'h40, 64'd0, SAOK, 1'b0);

        issue(1, 1'b1, 64'h8, 64'hA5A5_0123_4567_89AB, SAOK, 1'b0);
        issue(1, 1'b0, 64'h8, 64'd0, SAOK, 1'b0);
        idle(1);

        for (int i = 0; i < 300; i++) begin
            int sel;
            bit tog;
            sel = int'($urandom_range(0, 1));
            tog = (sel == 0) && ($urandom_range(0, 3) == 0);
            issue(sel, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom}, rand_stat(), tog);
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        idle(5);
        chk("a.queue_empty", 64'(qa.size()), 64'd0);
        chk("b.queue_empty", 64'(qb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_unit.md
# dmem_unit

Parametrised data-memory unit for the M stage of the Y86-64 pipeline. It replaces the single-cycle combinational data RAM with a request/done handshake, a configurable wait-state count, a configurable byte depth and a registered result. Each access carries a full address-range check that reports `SADR`. The pipeline control logic stalls the M register while `busy_o` is high.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in bytes; multiple of 8, ≥ 16.
- `WAIT_CYCLES`, 1: wait states inserted before each access; legal range 0..15.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  1  access request; sampled only when the unit can accept.
- `we_i`  in  1  1 = write 8 bytes, 0 = read 8 bytes.
- `addr_i`  in  64  byte address (the M-stage `valE` or `valA`, selected upstream).
- `wdata_i`  in  64  write data.
- `stat_i`  in  4  incoming instruction status (`SAOK`/`SHLT`/`SADR`/`SINS` from `define.v`).
- `busy_o`  out  1  access in progress; the pipeline holds the M register.
- `done_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  64  read data (`valM`); valid while `done_o` is high, then held.
- `stat_o`  out  4  completion status; valid while `done_o` is high, then held.

## Operation
- Storage is a byte array `[0:DEPTH-1]`. It is not cleared by reset; contents are undefined until written.
- 8-byte accesses are little-endian: byte `addr+k` maps to data bits `[8k+7:8k]`.
- FSM states:
  - IDLE: waiting for a request.
  - WAIT: wait-state countdown.
  - DONE: one-cycle completion.
- Reset values:
  - State = IDLE; wait counter = 0.
  - `busy_o` = 0, `done_o` = 0, `rdata_o` = 0, `stat_o` = `SAOK`.
- Acceptance: `req_i` = 1 while the state is IDLE or DONE. On acceptance, `we_i`, `addr_i`, `wdata_i` and `stat_i` are captured.
- Classification at acceptance, in priority order:
  1. `stat_i` ≠ `SAOK`: no memory access; next state DONE; `stat_o` = `stat_i`; `rdata_o` = 0.
  2. `addr_i` > `DEPTH-8` (full 64-bit unsigned compare): no access; next state DONE; `stat_o` = `SADR`; `rdata_o` = 0.
  3. Otherwise a valid access:
     - If `WAIT_CYCLES` = 0, the access executes at the acceptance edge; next state DONE.
     - Otherwise next state WAIT, with the counter loaded to `WAIT_CYCLES`.
- WAIT: the counter decrements each cycle. At the edge where the counter = 1:
  - The access executes: a write commits all 8 bytes, or a read loads `rdata_o`.
  - `stat_o` = `SAOK`; next state DONE.
- A completed write sets `rdata_o` = 0.
- DONE: `done_o` = 1 for this cycle only. Without a new request the next state is IDLE; with `req_i` = 1 a new request is accepted (back-to-back).
- `busy_o` = (state == WAIT), combinational from the state register.
- `req_i` while in WAIT is ignored. The requester holds `req_i` until it sees `done_o`.
- A non-AOK or out-of-range request never modifies memory.

## Timing
- A request sampled at edge N produces `done_o` high during cycle N+1+`WAIT_CYCLES`, i.e. latency is `WAIT_CYCLES`+1 cycles.
- Error and non-AOK requests always take 1 cycle, independent of `WAIT_CYCLES`.
- A write is visible to a read accepted in its DONE cycle.
- Peak throughput is one access per `WAIT_CYCLES`+1 cycles.
- `rdata_o` and `stat_o` are registered and change only at completion edges or reset.
- Reset asserted mid-operation (WAIT):
  - The access is aborted; no bytes are written; no `done_o` pulse.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
- Boundary addresses:
  - `DEPTH-8` is legal.
  - `DEPTH-7` is `SADR`.
  - `0xFFFF_FFFF_FFFF_FFF8` is `SADR`; the address check has no wrap-around.

## Test plan
- `WAIT_CYCLES`=2: write `0x1122334455667788` to `0x10`, then read `0x10`.
  - Each `done_o` occurs 3 cycles after its request, with `busy_o` high for the 2 intervening cycles.
  - Read returns `rdata_o` = `0x1122334455667788`; a byte read at `0x10` returns `0x88`; `stat_o` = `SAOK`.
- Address bounds, `DEPTH`=1024:
  - Write at 1016 succeeds.
  - Write at 1017 gives `stat_o` = `SADR`, `done_o` after 1 cycle, and memory bytes 1016..1023 unchanged on read-back.
  - Read at `0xFFFF_FFFF_FFFF_FFF8` gives `SADR`.
- Write with `stat_i` = `SHLT` to `0x20`: `done_o` after 1 cycle, `stat_o` = `SHLT`; a subsequent read of `0x20` returns the prior contents.
- Reset pulsed during WAIT of a write to `0x40`:
  - `busy_o`, `done_o`, `rdata_o` and `stat_o` reset asynchronously.
  - A later read of `0x40` returns the pre-write value.
- `WAIT_CYCLES`=0, back-to-back with `req_i` held high:
  - Write `A` to `0x8`, then read `0x8` accepted in the write's DONE cycle.
  - `done_o` is high on consecutive cycles; the read returns `A`.
- `req_i` toggled during WAIT: it is ignored, the original access completes unchanged, and no extra `done_o` pulse occurs.
